// File: rtl/dmem_port_if.sv
// Requester-side bus of the data-memory arbiter: one instance per port.
// Handshake: hold req high with we/size/sgn/addr/wdata stable until ack pulses for
// one cycle; rdata and err are meaningful in that ack cycle, and rdata stays put until the next ack.
interface dmem_port_if #(
  parameter int AW = 13
);
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          sgn;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack;
  logic          err;

  modport master (output req, we, size, sgn, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, size, sgn, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter and access sequencer for two requesters sharing a 2048x32 data memory.
// Sub-word stores are done as a read-modify-write because the memory only writes full words.
module dmem_port_arbiter #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_port_if.slave    p0,
  dmem_port_if.slave    p1,
  output logic          busy,
  output logic          mem_ena,
  output logic          mem_wena,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    state_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCESS = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] RMW_WR = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;
  localparam logic [2:0] ACK    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          last_grant_q;
  logic          gnt_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] old_word_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic          any_req;
  logic          win;
  logic          sel_we;
  logic [1:0]    sel_size;
  logic          sel_sgn;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_bad;

  logic [4:0]    lane_sh;
  logic [DW-1:0] lane_data;
  logic [DW-1:0] load_val;
  logic [DW-1:0] lane_mask;
  logic [DW-1:0] lane_ins;
  logic [DW-1:0] merged;

  // Arbitration: on a tie the port that did not win last time goes first.
  always_comb begin
    any_req = p0.req | p1.req;
    if (p0.req && p1.req) begin
      win = ~last_grant_q;
    end else begin
      win = p1.req;
    end
    sel_we    = win ? p1.we    : p0.we;
    sel_size  = win ? p1.size  : p0.size;
    sel_sgn   = win ? p1.sgn   : p0.sgn;
    sel_addr  = win ? p1.addr  : p0.addr;
    sel_wdata = win ? p1.wdata : p0.wdata;
    sel_bad   = (sel_size == 2'b11) ||
                ((sel_size == 2'b01) && sel_addr[0]) ||
                ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (!any_req) begin
          state_d = IDLE;
        end else if (sel_bad) begin
          state_d = ERR;
        end else if (sel_we && (sel_size != 2'b10)) begin
          state_d = RMW_RD;
        end else begin
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = ACK;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = ACK;
      ERR:     state_d = IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane selection; requests are already aligned, so a half lane shift is 0 or 16.
  always_comb begin
    lane_sh   = {addr_q[1:0], 3'b000};
    lane_data = mem_rdata >> lane_sh;
    case (size_q)
      2'b00:   load_val = {{24{sgn_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_val = {{16{sgn_q & lane_data[15]}}, lane_data[15:0]};
      default: load_val = mem_rdata;
    endcase
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00FF << lane_sh;
      lane_ins  = {24'd0, wdata_q[7:0]} << lane_sh;
    end else begin
      lane_mask = 32'h0000_FFFF << lane_sh;
      lane_ins  = {16'd0, wdata_q[15:0]} << lane_sh;
    end
    merged = (old_word_q & ~lane_mask) | (lane_ins & lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_word_q   <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && any_req) begin
        gnt_q        <= win;
        last_grant_q <= win;
        we_q         <= sel_we;
        size_q       <= sel_size;
        sgn_q        <= sel_sgn;
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
      end
      if (state_q == RMW_RD) begin
        old_word_q <= mem_rdata;
      end
      if ((state_q == ACCESS) && !we_q) begin
        if (gnt_q) begin
          rdata1_q <= load_val;
        end else begin
          rdata0_q <= load_val;
        end
      end
    end
  end

  // Memory strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    mem_ena   = (state_q == ACCESS) || (state_q == RMW_RD) || (state_q == RMW_WR);
    mem_wena  = ((state_q == ACCESS) && we_q) || (state_q == RMW_WR);
    mem_addr  = mem_ena ? addr_q[AW-1:2] : '0;
    if ((state_q == ACCESS) && we_q) begin
      mem_wdata = wdata_q;
    end else if (state_q == RMW_WR) begin
      mem_wdata = merged;
    end else begin
      mem_wdata = '0;
    end
    busy     = (state_q != IDLE);
    state_o  = state_q;
    p0.ack   = ((state_q == ERR) || (state_q == ACK)) && !gnt_q;
    p1.ack   = ((state_q == ERR) || (state_q == ACK)) && gnt_q;
    p0.err   = (state_q == ERR) && !gnt_q;
    p1.err   = (state_q == ERR) && gnt_q;
    p0.rdata = rdata0_q;
    p1.rdata = rdata1_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 2048x32 memory model that writes on negedge.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, mem_ena, mem_wena;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] order_q[$];

  logic [31:0] mem [0:2047];

  dmem_port_if p0_if ();
  dmem_port_if p1_if ();

  dmem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0        (p0_if),
    .p1        (p1_if),
    .busy      (busy),
    .mem_ena   (mem_ena),
    .mem_wena  (mem_wena),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state_o   (state_o)
  );

  // clock / reset / memory
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(negedge clk) begin
    if (mem_ena && mem_wena) mem[mem_addr] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int port, input logic req, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [12:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.size = size;
      p0_if.sgn = sgn; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.size = size;
      p1_if.sgn = sgn; p1_if.addr = addr; p1_if.wdata = wdata;
    end
  endtask

  // Called #1 after the posedge that opens cycle 0 (req already high).
  task automatic wait_ack(input int port, output int lat, output logic [31:0] rd, output logic er,
                          output logic saw_ena, output logic [10:0] acc_addr);
    logic a;
    lat = -1; rd = '0; er = 1'b0; saw_ena = 1'b0; acc_addr = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_ena) begin
        saw_ena  = 1'b1;
        acc_addr = mem_addr;
      end
      a = (port == 0) ? p0_if.ack : p1_if.ack;
      if (a) begin
        lat = c;
        rd  = (port == 0) ? p0_if.rdata : p1_if.rdata;
        er  = (port == 0) ? p0_if.err : p1_if.err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
  endtask

  task automatic xfer(input int port, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [12:0] addr, input logic [31:0] wdata,
                      output int lat, output logic [31:0] rd, output logic er,
                      output logic saw_ena, output logic [10:0] acc_addr);
    @(posedge clk); #1;
    drive(port, 1'b1, we, size, sgn, addr, wdata);
    wait_ack(port, lat, rd, er, saw_ena, acc_addr);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er, se;
  logic [10:0] aa;

  initial begin
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_ena", 32'(mem_ena), 32'd0);
    check("rst_mem_wena", 32'(mem_wena), 32'd0);
    check("rst_ack", 32'({p1_if.ack, p0_if.ack}), 32'd0);
    check("rst_rdata0", p0_if.rdata, 32'd0);
    rst_n = 1'b1;

    // word store and load
    xfer(0, 1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, lat, rd, er, se, aa);
    check("wst_lat", 32'(lat), 32'd2);
    check("wst_addr", 32'(aa), 32'h004);
    check("wst_err", 32'(er), 32'd0);
    xfer(0, 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, lat, rd, er, se, aa);
    check("wld_lat", 32'(lat), 32'd2);
    check("wld_data", rd, 32'hDEADBEEF);
    check("wld_addr", 32'(aa), 32'h004);

    // byte store as read-modify-write
    xfer(1, 1'b1, 2'b10, 1'b0, 13'h010, 32'h11223344, lat, rd, er, se, aa);
    check("p1_wst_lat", 32'(lat), 32'd2);
    check("freeze_rdata0", p0_if.rdata, 32'hDEADBEEF);
    xfer(0, 1'b1, 2'b00, 1'b0, 13'h013, 32'h0000005A, lat, rd, er, se, aa);
    check("bst_lat", 32'(lat), 32'd3);
    check("bst_mem", mem[4], 32'h5A223344);

    // sub-word loads and stores
    xfer(0, 1'b0, 2'b00, 1'b0, 13'h013, 32'h0, lat, rd, er, se, aa);
    check("bld_u", rd, 32'h0000005A);
    xfer(0, 1'b0, 2'b00, 1'b1, 13'h013, 32'h0, lat, rd, er, se, aa);
    check("bld_s_pos", rd, 32'h0000005A);
    xfer(0, 1'b0, 2'b01, 1'b1, 13'h012, 32'h0, lat, rd, er, se, aa);
    check("hld_s_pos", rd, 32'h00005A22);
    xfer(1, 1'b1, 2'b00, 1'b0, 13'h013, 32'hFFFFFFF0, lat, rd, er, se, aa);
    check("bst_f0_lat", 32'(lat), 32'd3);
    xfer(0, 1'b0, 2'b00, 1'b1, 13'h013, 32'h0, lat, rd, er, se, aa);
    check("bld_s_neg", rd, 32'hFFFFFFF0);
    xfer(1, 1'b0, 2'b01, 1'b1, 13'h012, 32'h0, lat, rd, er, se, aa);
    check("hld_s_neg", rd, 32'hFFFFF022);
    check("freeze_rdata0b", p0_if.rdata, 32'hFFFFFFF0);
    xfer(1, 1'b1, 2'b01, 1'b0, 13'h010, 32'h1234BEEF, lat, rd, er, se, aa);
    check("hst_lat", 32'(lat), 32'd3);
    check("hst_mem", mem[4], 32'hF022BEEF);
    xfer(0, 1'b0, 2'b00, 1'b0, 13'h011, 32'h0, lat, rd, er, se, aa);
    check("bld_lane1", rd, 32'h000000BE);
    xfer(1, 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, lat, rd, er, se, aa);
    check("wld_p1", rd, 32'hF022BEEF);

    // error requests
    xfer(0, 1'b1, 2'b10, 1'b0, 13'h000, 32'hCAFEF00D, lat, rd, er, se, aa);
    xfer(0, 1'b1, 2'b01, 1'b0, 13'h001, 32'h00001234, lat, rd, er, se, aa);
    check("err_hst_lat", 32'(lat), 32'd1);
    check("err_hst_err", 32'(er), 32'd1);
    check("err_hst_ena", 32'(se), 32'd0);
    check("err_hst_mem", mem[0], 32'hCAFEF00D);
    xfer(1, 1'b0, 2'b10, 1'b0, 13'h002, 32'h0, lat, rd, er, se, aa);
    check("err_wld_lat", 32'(lat), 32'd1);
    check("err_wld_err", 32'(er), 32'd1);
    check("err_wld_ena", 32'(se), 32'd0);
    xfer(0, 1'b0, 2'b11, 1'b0, 13'h000, 32'h0, lat, rd, er, se, aa);
    check("err_size_err", 32'(er), 32'd1);
    xfer(0, 1'b0, 2'b10, 1'b0, 13'h000, 32'h0, lat, rd, er, se, aa);
    check("ok_after_err", 32'(er), 32'd0);

    // reset during RMW_RD
    xfer(0, 1'b1, 2'b10, 1'b0, 13'h020, 32'hAABBCCDD, lat, rd, er, se, aa);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 2'b00, 1'b0, 13'h021, 32'h00000077);
    @(posedge clk); #2;
    check("rmw_rd_state", 32'(state_o), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rstmid_wena", 32'(mem_wena), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ack", 32'(p0_if.ack), 32'd0);
    @(negedge clk);
    check("rstmid_mem", mem[8], 32'hAABBCCDD);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ack(0, lat, rd, er, se, aa);
    check("rstmid_lat", 32'(lat), 32'd3);
    check("rstmid_mem_after", mem[8], 32'hAABB77DD);

    // both ports requesting continuously from reset
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 13'h010, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 13'h000, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (p0_if.ack) order_q.push_back(32'd0);
      if (p1_if.ack) order_q.push_back(32'd1);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    check("rr_count_ge4", 32'(order_q.size() >= 4), 32'd1);
    while (exp_q.size() > 0) begin
      if (order_q.size() > 0) begin
        check("rr_order", order_q.pop_front(), exp_q.pop_front());
      end else begin
        check("rr_order_missing", 32'hFFFFFFFF, exp_q.pop_front());
      end
    end
    check("rr_rdata0", p0_if.rdata, 32'hF022BEEF);
    check("rr_rdata1", p1_if.rdata, 32'hCAFEF00D);
    check("rr_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
